// File: rtl/mem_arbiter_pkg.sv
// Shared types for the core/host memory arbiter: FSM states, response
// steering tags, core-side opcode/source enums and the starvation counter step.
package mem_arbiter_pkg;

  // Arbiter ownership state.
  typedef enum logic [0:0] {
    ARB   = 1'b0,  // normal arbitration, core has priority
    HLOCK = 1'b1   // host owns the memory for back-to-back accesses
  } arb_state_t;

  // Which port the read data returning next cycle belongs to.
  typedef enum logic [1:0] {
    NONE = 2'd0,
    CORE = 2'd1,
    HOST = 2'd2
  } resp_tag_t;

  // Kind of access the core issues on its port.
  typedef enum logic [1:0] {
    OP_FETCH = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2
  } opcode_t;

  // Requester identity.
  typedef enum logic [0:0] {
    SRC_CORE = 1'b0,
    SRC_HOST = 1'b1
  } src_t;

  // Saturating increment of the starvation counter.
  function automatic logic [3:0] sat_inc(input logic [3:0] cnt, input logic [3:0] max);
    logic [3:0] res;
    if (cnt < max) begin
      res = cnt + 4'd1;
    end else begin
      res = max;
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (core/host) single-memory arbiter. Core has priority, the host is
// guaranteed a grant after STARVE_MAX contested core wins, and the host may
// lock the memory for back-to-back accesses. Read data returns one cycle after
// the grant and is steered to the requesting port by a registered tag.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // core port
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [31:0]       c_wdata,
  input  logic [3:0]        c_wstrb,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [31:0]       c_rdata,
  // host port
  input  logic              h_req,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [31:0]       h_wdata,
  input  logic [3:0]        h_wstrb,
  input  logic              h_lock,
  output logic              h_gnt,
  output logic              h_rvalid,
  output logic [31:0]       h_rdata,
  // memory side
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [31:0]       mem_rdata
);

  localparam logic [3:0] STARVE_MAX_C = 4'(STARVE_MAX);

  arb_state_t state_q, state_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  resp_tag_t  tag_q, tag_d;
  logic       c_rvalid_q, c_rvalid_d;
  logic       h_rvalid_q, h_rvalid_d;
  logic       c_gnt_s, h_gnt_s;

  // Grant decision: core priority in ARB unless the host is starved; host only while it holds the lock.
  always_comb begin
    c_gnt_s = 1'b0;
    h_gnt_s = 1'b0;
    if (!rst_n) begin
      c_gnt_s = 1'b0;
      h_gnt_s = 1'b0;
    end else begin
      case (state_q)
        HLOCK: begin
          if (h_req) begin
            h_gnt_s = 1'b1;
          end else if (c_req) begin
            c_gnt_s = 1'b1;
          end else begin
            c_gnt_s = 1'b0;
          end
        end
        ARB: begin
          if (c_req && h_req) begin
            if (starve_cnt_q == STARVE_MAX_C) begin
              h_gnt_s = 1'b1;
            end else begin
              c_gnt_s = 1'b1;
            end
          end else if (c_req) begin
            c_gnt_s = 1'b1;
          end else if (h_req) begin
            h_gnt_s = 1'b1;
          end else begin
            c_gnt_s = 1'b0;
          end
        end
        default: begin
          c_gnt_s = 1'b0;
          h_gnt_s = 1'b0;
        end
      endcase
    end
  end

  // Next FSM state, starvation count and read-response tag from this cycle's grant.
  always_comb begin
    state_d      = ARB;
    starve_cnt_d = 4'd0;
    tag_d        = NONE;
    c_rvalid_d   = 1'b0;
    h_rvalid_d   = 1'b0;

    // A locked host grant keeps ownership; anything else (incl. an idle host) returns to ARB.
    if (h_gnt_s && h_lock) begin
      state_d = HLOCK;
    end else begin
      state_d = ARB;
    end

    // Count only contested core wins; any host grant or idle host clears the count.
    if (state_q == HLOCK) begin
      starve_cnt_d = 4'd0;
    end else if (h_gnt_s || !h_req) begin
      starve_cnt_d = 4'd0;
    end else if (c_gnt_s) begin
      starve_cnt_d = sat_inc(starve_cnt_q, STARVE_MAX_C);
    end else begin
      starve_cnt_d = starve_cnt_q;
    end

    if (c_gnt_s && !c_we) begin
      tag_d      = CORE;
      c_rvalid_d = 1'b1;
    end else if (h_gnt_s && !h_we) begin
      tag_d      = HOST;
      h_rvalid_d = 1'b1;
    end else begin
      tag_d = NONE;
    end
  end

  // State and response registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ARB;
      starve_cnt_q <= 4'd0;
      tag_q        <= NONE;
      c_rvalid_q   <= 1'b0;
      h_rvalid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      tag_q        <= tag_d;
      c_rvalid_q   <= c_rvalid_d;
      h_rvalid_q   <= h_rvalid_d;
    end
  end

  // Memory request mux from whichever port holds the grant; idle drives zeros.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = 32'd0;
    mem_wstrb = 4'd0;
    if (h_gnt_s) begin
      mem_we    = h_we;
      mem_addr  = h_addr;
      mem_wdata = h_wdata;
      mem_wstrb = h_wstrb;
    end else if (c_gnt_s) begin
      mem_we    = c_we;
      mem_addr  = c_addr;
      mem_wdata = c_wdata;
      mem_wstrb = c_wstrb;
    end else begin
      mem_we    = 1'b0;
      mem_addr  = {ADDR_W{1'b0}};
      mem_wdata = 32'd0;
      mem_wstrb = 4'd0;
    end
  end

  // Read data steering by the tag registered in the grant cycle.
  always_comb begin
    c_rdata = 32'd0;
    h_rdata = 32'd0;
    case (tag_q)
      CORE: c_rdata = mem_rdata;
      HOST: h_rdata = mem_rdata;
      default: begin
        c_rdata = 32'd0;
        h_rdata = 32'd0;
      end
    endcase
  end

  assign c_gnt  = c_gnt_s;
  assign h_gnt  = h_gnt_s;
  assign mem_en = c_gnt_s | h_gnt_s;

  // A response already in flight is dropped while reset is held.
  assign c_rvalid = c_rvalid_q & rst_n;
  assign h_rvalid = h_rvalid_q & rst_n;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, the byte address width of both ports and the memory.
REQ-002 SHALL have parameter STARVE_MAX, default 4, the number of consecutive contested core wins before the host is forced a grant (legal range 1..15).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have core-port inputs c_req (1), c_we (1), c_addr (ADDR_W), c_wdata (32) and c_wstrb (4), carrying the core's fetch, load and store requests.
REQ-006 SHALL have core-port outputs c_gnt (1, combinational), c_rvalid (1, registered) and c_rdata (32); the core stalls its cycle while c_req=1 and c_gnt=0.
REQ-007 SHALL have host-port inputs h_req, h_we, h_addr, h_wdata and h_wstrb, with the same widths as the core port, plus h_lock (1) to request back-to-back ownership.
REQ-008 SHALL have host-port outputs h_gnt, h_rvalid and h_rdata, with the same widths and timing as the core port.
REQ-009 SHALL have memory-side outputs mem_en (1), mem_we (1), mem_addr (ADDR_W), mem_wdata (32) and mem_wstrb (4), and input mem_rdata (32), valid one cycle after a read enable.

Function
REQ-010 SHALL implement FSM states ARB (core priority) and HLOCK (host owns the memory).
REQ-011 In ARB, a lone requester SHALL be granted in the same cycle; with no request, mem_en=0.
REQ-012 In ARB with both requesting, the core SHALL win unless starve_cnt==STARVE_MAX, in which case the host wins.
REQ-013 starve_cnt (4-bit) SHALL increment, saturating at STARVE_MAX, on each cycle both request and the core is granted.
REQ-014 starve_cnt SHALL clear on any host grant or any cycle with h_req=0.
REQ-015 A host grant in ARB with h_lock=1 SHALL move the FSM to HLOCK next cycle.
REQ-016 In HLOCK, a cycle with h_req=1 SHALL grant the host and never the core; if h_lock=0 in that granted cycle, that access is the last one and the next state is ARB.
REQ-017 In HLOCK, a cycle with h_req=0 SHALL follow the ARB rules (core may be granted) and return the FSM to ARB; starve_cnt SHALL be held at 0 in HLOCK.
REQ-018 At most one of c_gnt and h_gnt SHALL be 1 in any cycle.
REQ-019 mem_en SHALL equal c_gnt|h_gnt; mem_we, mem_addr, mem_wdata and mem_wstrb SHALL be muxed combinationally from the granted port.
REQ-020 A granted read SHALL produce a one-cycle rvalid on the same port exactly one cycle later, with rdata equal to mem_rdata in that cycle.
REQ-021 A granted write SHALL complete in its grant cycle and produce no rvalid.
REQ-022 A registered response tag (NONE/CORE/HOST) SHALL steer the read response, so the response of cycle N is unaffected by the grant of cycle N+1.
REQ-023 Requesters SHALL hold req, we, addr, wdata and wstrb stable until gnt; the arbiter SHALL sample them only in the grant cycle.
REQ-024 Back-to-back grants to the same or alternating ports SHALL be supported every cycle, with no bubble.

Reset
REQ-025 While rst_n=0, c_gnt, h_gnt, mem_en and mem_we SHALL be forced to 0.
REQ-026 On a clock edge with rst_n=0: FSM=ARB, starve_cnt=0, tag=NONE, c_rvalid=0, h_rvalid=0.
REQ-027 Reset asserted mid-operation SHALL cancel any pending read response (no rvalid in the cycle after reset) and exit HLOCK.

Structure
REQ-028 The arb_state_t enum (ARB, HLOCK) and the resp_tag_t enum (NONE, CORE, HOST) SHALL live in the shared package with the core's opcode and src enums.
REQ-029 The block SHALL be a single module with no sub-modules; port muxing is inline.

Verification
REQ-030 Bench: c_req=1 read at 0x100 alone -> c_gnt=1 same cycle; c_rvalid=1 next cycle with c_rdata = memory word at 0x100.
REQ-031 Bench: both request continuously, STARVE_MAX=4 -> grants CCCCH CCCCH...; h_gnt on cycles 5, 10, ...
REQ-032 Bench: host read granted cycle N, core read granted cycle N+1 -> h_rvalid at N+1, c_rvalid at N+2, each with its own data.
REQ-033 Bench: host h_lock=1 for 3 accesses, core requesting throughout -> h_gnt for 3 consecutive cycles, then c_gnt.
REQ-034 Bench: rst_n=0 in the cycle after a granted core read -> no c_rvalid; FSM=ARB and starve_cnt=0 after release.
REQ-035 Bench: core write (c_wstrb=4'b0011) -> mem_we=1 with mem_wstrb=4'b0011 in the grant cycle; no c_rvalid follows.
